lin_schedule_executor: RTL and testbench

- Sits directly downstream of the LIN master controller.
- While the controller asserts en_operation and read_from_mem, the block walks the schedule table ROM one entry at a time.
- For each valid entry it decodes the frame slot, issues one header request to the LIN frame engine and times the slot in base ticks before moving to the next entry.
- It reports schedule wrap, frame errors and an empty-table condition back to the controller and application.

---
 rtl/lin_sched_pkg.sv | 24 ++
 rtl/lin_slot_timer.sv | 44 ++++
 rtl/lin_schedule_executor.sv | 222 ++++++++++++++++++++++
 tb/tb_lin_schedule_executor.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lin_sched_pkg.sv
// Shared definitions for the LIN schedule executor.
//   - Bit positions of the fields in a 32-bit schedule table entry.
//   - Executor state encoding.
//   - MAX_LEN: largest LIN data length; out-of-range lengths clamp to it.
package lin_sched_pkg;

    localparam int unsigned PID_LSB   = 0;
    localparam int unsigned DIR_BIT   = 6;
    localparam int unsigned LEN_LSB   = 7;
    localparam int unsigned SLOT_LSB  = 11;
    localparam int unsigned VALID_BIT = 30;
    localparam int unsigned END_BIT   = 31;

    localparam logic [3:0] MAX_LEN = 4'd8;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        ISSUE,
        SLOT
    } state_e;

endpackage

// File: rtl/lin_slot_timer.sv
// Loadable slot down-counter driven by the slot time base.
// Ports:
//   clk, reset   - clock, asynchronous active-low reset
//   load_i       - load load_val_i into the counter
//   load_val_i   - slot length in ticks (caller guarantees non-zero)
//   tick_i       - time-base pulse; decrements a non-zero counter
//   clr_i        - force the counter to zero (has priority over load)
//   expire_o     - one-cycle pulse: the tick that consumes the last count
module lin_slot_timer #(
    parameter int unsigned SLOT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [SLOT_W-1:0] load_val_i,
    input  logic              tick_i,
    input  logic              clr_i,
    output logic              expire_o
);

    logic [SLOT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (tick_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = tick_i && (cnt_q == SLOT_W'(1));

endmodule

// File: rtl/lin_schedule_executor.sv
// LIN schedule executor: walks the schedule table ROM while the master
// controller grants en_operation and read_from_mem, issues one header
// request per valid entry and holds each slot for its programmed tick count.
// Optional feature macro: LIN_SCHED_MISS_CNT_EN adds miss_count.
// Ports:
//   clk, reset        - clock, asynchronous active-low reset
//   en_operation      - run enable
//   read_from_mem     - table-read permission
//   tick              - slot time-base pulse
//   rom_data          - entry at rom_addr (combinational ROM)
//   frame_done/error  - frame engine completion / error pulses
//   rom_addr          - table pointer
//   hdr_start         - one-cycle header request
//   hdr_pid/dir/len   - header fields, held until the next request
//   slot_active       - high for the duration of a slot
//   sched_wrap        - pulse when the pointer returns to entry 0
//   table_empty       - sticky: entry 0 is an end marker
//   err_count         - saturating frame_error count
//   miss_count        - (optional) saturating count of silent slots
module lin_schedule_executor
    import lin_sched_pkg::*;
#(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned SLOT_W = 8,
    parameter int unsigned ERR_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_operation,
    input  logic              read_from_mem,
    input  logic              tick,
    input  logic [31:0]       rom_data,
    input  logic              frame_done,
    input  logic              frame_error,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              hdr_start,
    output logic [5:0]        hdr_pid,
    output logic              hdr_dir,
    output logic [3:0]        hdr_len,
    output logic              slot_active,
    output logic              sched_wrap,
    output logic              table_empty,
    output logic [ERR_W-1:0]  err_count
`ifdef LIN_SCHED_MISS_CNT_EN
    ,
    output logic [7:0]        miss_count
`endif
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [31:0]       entry_q;
    logic              start_q, start_d;
    logic              wrap_q, wrap_d;
    logic              active_q, active_d;
    logic              empty_q, empty_d;
    logic [5:0]        pid_q;
    logic              dir_q;
    logic [3:0]        len_q;
    logic [ERR_W-1:0]  err_q;
    logic              latch_entry, issue, clr_timer, expire, run;
    logic [3:0]        len_raw, len_clamped;
    logic [SLOT_W-1:0] slot_raw, slot_load;

    assign run         = en_operation && read_from_mem;
    assign len_raw     = entry_q[LEN_LSB +: 4];
    assign len_clamped = ((len_raw == 4'd0) || (len_raw > MAX_LEN)) ? MAX_LEN : len_raw;
    assign slot_raw    = entry_q[SLOT_LSB +: SLOT_W];
    assign slot_load   = (slot_raw == '0) ? SLOT_W'(1) : slot_raw;

    logic unused_entry_bits;
    assign unused_entry_bits = ^entry_q[VALID_BIT-1:SLOT_LSB+SLOT_W];

    lin_slot_timer #(
        .SLOT_W(SLOT_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (issue),
        .load_val_i (slot_load),
        .tick_i     (tick),
        .clr_i      (clr_timer),
        .expire_o   (expire)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        start_d     = 1'b0;
        wrap_d      = 1'b0;
        active_d    = active_q;
        empty_d     = empty_q;
        latch_entry = 1'b0;
        issue       = 1'b0;
        clr_timer   = 1'b0;
        case (state_q)
            IDLE: begin
                if (run && !empty_q) state_d = FETCH;
            end
            FETCH: begin
                latch_entry = 1'b1;
                state_d     = DECODE;
            end
            DECODE: begin
                if (entry_q[END_BIT] && (ptr_q == '0)) begin
                    empty_d = 1'b1;
                    state_d = IDLE;
                end else if (entry_q[END_BIT]) begin
                    ptr_d   = '0;
                    wrap_d  = 1'b1;
                    state_d = FETCH;
                end else if (!entry_q[VALID_BIT]) begin
                    ptr_d   = ptr_q + 1'b1;
                    wrap_d  = (ptr_q == '1);
                    state_d = FETCH;
                end else begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                start_d  = 1'b1;
                issue    = 1'b1;
                active_d = 1'b1;
                state_d  = SLOT;
            end
            SLOT: begin
                if (expire) begin
                    active_d = 1'b0;
                    ptr_d    = ptr_q + 1'b1;
                    wrap_d   = (ptr_q == '1);
                    state_d  = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase

        // Losing the run grant overrides every state action: nothing is
        // issued or advanced, so the same entry is re-fetched on resume.
        if ((state_q != IDLE) && !run) begin
            state_d     = IDLE;
            ptr_d       = ptr_q;
            start_d     = 1'b0;
            wrap_d      = 1'b0;
            active_d    = 1'b0;
            empty_d     = empty_q;
            latch_entry = 1'b0;
            issue       = 1'b0;
            clr_timer   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            entry_q  <= '0;
            start_q  <= 1'b0;
            wrap_q   <= 1'b0;
            active_q <= 1'b0;
            empty_q  <= 1'b0;
            pid_q    <= '0;
            dir_q    <= 1'b0;
            len_q    <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            start_q  <= start_d;
            wrap_q   <= wrap_d;
            active_q <= active_d;
            empty_q  <= empty_d;
            if (latch_entry) entry_q <= rom_data;
            if (issue) begin
                pid_q <= entry_q[PID_LSB +: 6];
                dir_q <= entry_q[DIR_BIT];
                len_q <= len_clamped;
            end
            if (frame_error && (err_q != '1)) err_q <= err_q + 1'b1;
        end
    end

`ifdef LIN_SCHED_MISS_CNT_EN
    logic       seen_q;
    logic [7:0] miss_q;
    logic       slot_end;

    assign slot_end = (state_q == SLOT) && run && expire;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seen_q <= 1'b0;
            miss_q <= '0;
        end else begin
            if (issue) begin
                seen_q <= 1'b0;
            end else if ((state_q == SLOT) && (frame_done || frame_error)) begin
                seen_q <= 1'b1;
            end
            // Events on the final slot cycle still count as a response.
            if (slot_end && !(seen_q || frame_done || frame_error) && (miss_q != '1)) begin
                miss_q <= miss_q + 1'b1;
            end
        end
    end

    assign miss_count = miss_q;
`else
    logic unused_frame_done;
    assign unused_frame_done = frame_done;
`endif

    assign rom_addr    = ptr_q;
    assign hdr_start   = start_q;
    assign hdr_pid     = pid_q;
    assign hdr_dir     = dir_q;
    assign hdr_len     = len_q;
    assign slot_active = active_q;
    assign sched_wrap  = wrap_q;
    assign table_empty = empty_q;
    assign err_count   = err_q;

endmodule

// File: tb/tb_lin_schedule_executor.sv
module tb_lin_schedule_executor;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned SLOT_W = 8;
    localparam int unsigned ERR_W  = 8;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic reset, en_operation, read_from_mem, tick, frame_done, frame_error;
    logic [31:0] rom_data;
    logic [ADDR_W-1:0] rom_addr;
    logic hdr_start, hdr_dir, slot_active, sched_wrap, table_empty;
    logic [5:0] hdr_pid;
    logic [3:0] hdr_len;
    logic [ERR_W-1:0] err_count;
`ifdef LIN_SCHED_MISS_CNT_EN
    logic [7:0] miss_count;
`endif

    logic [31:0] rom [DEPTH];
    assign rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    lin_schedule_executor #(
        .ADDR_W(ADDR_W),
        .SLOT_W(SLOT_W),
        .ERR_W (ERR_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .en_operation (en_operation),
        .read_from_mem(read_from_mem),
        .tick         (tick),
        .rom_data     (rom_data),
        .frame_done   (frame_done),
        .frame_error  (frame_error),
        .rom_addr     (rom_addr),
        .hdr_start    (hdr_start),
        .hdr_pid      (hdr_pid),
        .hdr_dir      (hdr_dir),
        .hdr_len      (hdr_len),
        .slot_active  (slot_active),
        .sched_wrap   (sched_wrap),
        .table_empty  (table_empty),
        .err_count    (err_count)
`ifdef LIN_SCHED_MISS_CNT_EN
        ,
        .miss_count   (miss_count)
`endif
    );

    typedef struct {
        int idx;
        int pid;
        int dir;
        int len;
        int ticks;
        int wraps;
    } hdr_t;

    hdr_t exp_q[$];
    hdr_t cur;

    int checks = 0;
    int passed = 0;

    // stimulus controls
    bit tick_on = 0;
    int fd_mode = 0;   // 0 off, 1 random, 2 always high
    int fe_mode = 0;   // 0 off, 1 random, 2 alternate-cycle burst
    int fe_left = 0;

    // monitor state / reference
    int hdr_seen = 0, wrap_seen = 0, tick_cnt = 0, cur_ticks = 0;
    int last_idx = -1, err_exp = 0, exp_miss = 0, slot_ends = 0;
    bit in_slot = 0, aborted = 0, seen_frame = 0, prev_active = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endfunction

    function automatic logic [31:0] mk(input int pid, input int dir, input int len,
                                       input int ticks, input int valid, input int endm);
        logic [5:0] p;
        logic [3:0] l;
        logic [7:0] t;
        p = pid[5:0];
        l = len[3:0];
        t = ticks[7:0];
        return {endm[0], valid[0], 11'b0, t, l, dir[0], p};
    endfunction

    // Reference walk of the table: expected header stream from a start index.
    task automatic push_stream(input int start, input int n);
        int p, wr, cnt, guard, l, t;
        logic [31:0] e;
        hdr_t h;
        p = start; wr = 0; cnt = 0; guard = 0;
        while (cnt < n && guard < 5000) begin
            guard++;
            e = rom[p];
            if (e[31]) begin
                if (p == 0) break;
                wr++;
                p = 0;
            end else if (!e[30]) begin
                p = (p + 1) % DEPTH;
                if (p == 0) wr++;
            end else begin
                l = int'(e[10:7]);
                if (l == 0 || l > 8) l = 8;
                t = int'(e[18:11]);
                if (t == 0) t = 1;
                h.idx = p; h.pid = int'(e[5:0]); h.dir = int'(e[6]);
                h.len = l; h.ticks = t; h.wraps = wr;
                exp_q.push_back(h);
                wr = 0;
                cnt++;
                p = (p + 1) % DEPTH;
                if (p == 0) wr++;
            end
        end
    endtask

    // tick generator
    initial begin
        tick = 1'b0;
        forever begin
            @(posedge clk); #1;
            tick = tick_on && ($urandom_range(0, 2) == 0);
        end
    end

    // frame engine response generator
    initial begin
        frame_done = 1'b0;
        frame_error = 1'b0;
        forever begin
            @(posedge clk); #1;
            frame_done = (fd_mode == 2) || ((fd_mode == 1) && ($urandom_range(0, 3) == 0));
            if (fe_mode == 2) begin
                frame_error = !frame_error && (fe_left > 0);
                if (frame_error) fe_left--;
            end else begin
                frame_error = (fe_mode == 1) && ($urandom_range(0, 7) == 0);
            end
        end
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            wrap_seen = 0; prev_active = 0; in_slot = 0; err_exp = 0; exp_miss = 0;
        end else begin
            if (frame_error && err_exp < 255) err_exp++;
            if (sched_wrap) wrap_seen++;
            if (hdr_start) begin
                hdr_seen++;
                chk("wrap_hdr_exclusive", sched_wrap, 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL hdr_unexpected: got hdr_start pid=%0d, required none", hdr_pid);
                end else begin
                    cur = exp_q.pop_front();
                    chk("hdr_pid", hdr_pid, cur.pid);
                    chk("hdr_dir", hdr_dir, cur.dir);
                    chk("hdr_len", hdr_len, cur.len);
                    chk("wraps_before_hdr", wrap_seen, cur.wraps);
                    cur_ticks = cur.ticks;
                    last_idx = cur.idx;
                end
                wrap_seen = 0; tick_cnt = 0; aborted = 0; seen_frame = 0; in_slot = 1;
            end
            if (slot_active) begin
                if (tick) tick_cnt++;
                if (frame_done || frame_error) seen_frame = 1;
                if (!(en_operation && read_from_mem)) aborted = 1;
            end
            if (prev_active && !slot_active && in_slot) begin
                in_slot = 0;
                if (!aborted) begin
                    slot_ends++;
                    chk("slot_ticks", tick_cnt, cur_ticks);
                    if (!seen_frame && exp_miss < 255) exp_miss++;
                end
            end
            prev_active = slot_active;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic run();
        @(posedge clk); #1;
        en_operation = 1'b1;
        read_from_mem = 1'b1;
        tick_on = 1'b1;
    endtask

    task automatic stop_run();
        @(posedge clk); #1;
        en_operation = 1'b0;
        read_from_mem = 1'b0;
        fd_mode = 0;
        fe_mode = 0;
        repeat (4) @(posedge clk);
        exp_q.delete();
        @(negedge clk);
        chk("slot_inactive_idle", slot_active, 0);
        chk("err_count", err_count, err_exp);
`ifdef LIN_SCHED_MISS_CNT_EN
        chk("miss_count", miss_count, exp_miss);
`endif
    endtask

    task automatic wait_hdrs(input int n, input string name);
        int target, cyc;
        target = hdr_seen + n;
        cyc = 0;
        while (hdr_seen < target && cyc < 3000) begin
            @(posedge clk);
            cyc++;
        end
        chk(name, hdr_seen >= target, 1);
    endtask

    task automatic wait_ends(input int n, input string name);
        int target, cyc;
        target = slot_ends + n;
        cyc = 0;
        while (slot_ends < target && cyc < 3000) begin
            @(posedge clk);
            cyc++;
        end
        chk(name, slot_ends >= target, 1);
    endtask

    task automatic load_basic();
        for (int i = 0; i < DEPTH; i++) rom[i] = '0;
        rom[0] = mk(6'h10, 1, 2, 5, 1, 0);
        rom[1] = mk(0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        int cyc, hs;
        reset = 1'b0;
        en_operation = 1'b0;
        read_from_mem = 1'b0;
        for (int i = 0; i < DEPTH; i++) rom[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hdr_start", hdr_start, 0);
        chk("rst_slot_active", slot_active, 0);
        chk("rst_sched_wrap", sched_wrap, 0);
        chk("rst_table_empty", table_empty, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_hdr_fields", {hdr_pid, hdr_dir, hdr_len}, 0);

        // single entry + end marker, wraps every pass
        load_basic();
        do_reset();
        push_stream(0, 40);
        run();
        fd_mode = 1;
        fe_mode = 1;
        wait_hdrs(6, "basic_hdrs");
        stop_run();

        // empty table
        for (int i = 0; i < DEPTH; i++) rom[i] = '0;
        rom[0] = mk(0, 0, 0, 0, 0, 1);
        do_reset();
        hs = hdr_seen;
        run();
        cyc = 0;
        while (!table_empty && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("table_empty_set", table_empty, 1);
        repeat (10) @(posedge clk);
        stop_run();
        run();
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("table_empty_sticky", table_empty, 1);
        chk("empty_no_hdr", hdr_seen, hs);
        chk("empty_addr", rom_addr, 0);
        stop_run();
        do_reset();
        @(negedge clk);
        chk("table_empty_cleared", table_empty, 0);

        // skipped entry, length clamp, zero slot time
        for (int i = 0; i < DEPTH; i++) rom[i] = '0;
        rom[0] = mk(6'h01, 0, 0, 2, 1, 0);
        rom[1] = mk(6'h02, 1, 3, 4, 0, 0);
        rom[2] = mk(6'h03, 1, 9, 0, 1, 0);
        rom[3] = mk(0, 0, 0, 0, 0, 1);
        do_reset();
        push_stream(0, 40);
        run();
        fd_mode = 1;
        wait_hdrs(6, "skip_hdrs");
        stop_run();

        // abort mid-slot at entry 2, resume
        for (int i = 0; i < DEPTH; i++) rom[i] = '0;
        rom[0] = mk(6'h21, 0, 1, 3, 1, 0);
        rom[1] = mk(6'h22, 1, 4, 4, 1, 0);
        rom[2] = mk(6'h23, 0, 8, 6, 1, 0);
        rom[3] = mk(6'h24, 1, 5, 3, 1, 0);
        rom[4] = mk(0, 0, 0, 0, 0, 1);
        do_reset();
        last_idx = -1;
        push_stream(0, 20);
        run();
        cyc = 0;
        while (!(in_slot && last_idx == 2) && cyc < 2000) begin
            @(posedge clk);
            cyc++;
        end
        chk("abort_reached_entry2", last_idx, 2);
        #1 en_operation = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_slot_active", slot_active, 0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("resume_addr", rom_addr, 2);
        exp_q.delete();
        push_stream(2, 20);
        @(posedge clk); #1 en_operation = 1'b1;
        wait_hdrs(4, "resume_hdrs");
        stop_run();

        // error counter saturation while slots keep running
        load_basic();
        do_reset();
        push_stream(0, 80);
        run();
        fe_left = 300;
        fe_mode = 2;
        cyc = 0;
        while (fe_left > 0 && cyc < 2000) begin
            @(posedge clk);
            cyc++;
        end
        chk("err_burst_done", fe_left, 0);
        wait_hdrs(1, "err_hdrs");
        @(negedge clk);
        chk("err_saturated", err_count, 255);
        stop_run();

        // randomized tables
        for (int r = 0; r < 3; r++) begin
            rom[0] = mk(int'($urandom_range(0, 63)), int'($urandom_range(0, 1)),
                        int'($urandom_range(0, 15)), int'($urandom_range(0, 4)), 1, 0);
            for (int i = 1; i < DEPTH; i++)
                rom[i] = mk(int'($urandom_range(0, 63)), int'($urandom_range(0, 1)),
                            int'($urandom_range(0, 15)), int'($urandom_range(0, 4)),
                            int'($urandom_range(0, 9) < 7), int'($urandom_range(0, 9) == 0));
            do_reset();
            push_stream(0, 200);
            run();
            fd_mode = 1;
            fe_mode = 1;
            wait_hdrs(20, "rand_hdrs");
            stop_run();
        end

`ifdef LIN_SCHED_MISS_CNT_EN
        // silent slots counted, answered slots not
        load_basic();
        do_reset();
        push_stream(0, 40);
        run();
        wait_ends(3, "miss_three_slots");
        @(posedge clk); #1 fd_mode = 2;
        @(negedge clk);
        chk("miss_after_three", miss_count, 3);
        wait_ends(2, "answered_slots");
        @(negedge clk);
        chk("miss_unchanged", miss_count, 3);
        stop_run();
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
